down_counter: RTL
=================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and load-value width in bits.
REQ-002 i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_load  input  1  load strobe; samples i_load_value on the same rising edge.
REQ-005 i_load_value  input  WIDTH  start value for the countdown.
REQ-006 i_enable  input  1  decrement enable; low = pause.
REQ-007 o_count  output  WIDTH  current count, registered.
REQ-008 o_busy  output  1  high while in RUN.
REQ-009 o_done  output  1  one-cycle terminal-count pulse.
REQ-010 o_zero  output  1  high whenever o_count == 0.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE; o_busy = (state == RUN) and o_done = (state == DONE), both decoded from registered state.
REQ-012 IDLE: i_load=1 with i_load_value != 0 SHALL set o_count = i_load_value and enter RUN; i_load=1 with value 0 SHALL keep IDLE with o_count = 0.
REQ-013 RUN: i_load=0 and i_enable=1 SHALL decrement o_count by 1 per edge; i_enable=0 SHALL hold o_count.
REQ-014 RUN with o_count == 1 and i_enable=1 SHALL set o_count = 0 and enter DONE on that edge.
REQ-015 DONE SHALL last exactly one cycle and return to IDLE with o_count = 0, when the auto-reload feature (REQ-023) is compiled out.
REQ-016 i_load SHALL take priority over decrement in every state: a nonzero value restarts RUN at that value, and value 0 forces IDLE with o_count = 0 and no o_done pulse.
REQ-017 Latency: a load of N followed by i_enable held high SHALL show o_count = N on the first cycle after the load edge and o_count = 0 with o_done = 1 N cycles later.
REQ-018 The counter SHALL never wrap: o_count SHALL not decrement below 0, and o_count SHALL not change in IDLE without i_load.
REQ-019 Max value 2^WIDTH-1 SHALL load and count down normally.

Reset
REQ-020 i_reset=1 SHALL on the next rising edge force state IDLE, o_count = 0, o_busy = 0, o_done = 0 and o_zero = 1.
REQ-021 i_reset SHALL take priority over i_load and i_enable.
REQ-022 Reset asserted in RUN or DONE SHALL abort the countdown without producing an o_done pulse.

Configuration
REQ-023 Macro DOWN_COUNTER_AUTORELOAD_EN defined: the block SHALL hold a WIDTH-bit reload register, written on every i_load, and on leaving DONE it SHALL load o_count from that register and enter RUN, independent of i_enable.
REQ-024 With DOWN_COUNTER_AUTORELOAD_EN defined, i_load with value 0 SHALL stop auto-reload, enter IDLE and clear the reload register.
REQ-025 Macro undefined: no reload register SHALL exist, and DONE SHALL always return to IDLE per REQ-015.

Verification (WIDTH=4)
REQ-026 Reset held for 2 cycles, then released -> o_count=0, o_zero=1, o_busy=0, o_done=0.
REQ-027 Load 5 with i_enable high -> o_count 5,4,3,2,1,0 on consecutive cycles; o_done=1 only in the cycle showing 0, then o_busy=0.
REQ-028 Load 3, i_enable low for 4 cycles, then high -> o_count holds 3 for 4 cycles, then 2,1,0 with o_done pulse.
REQ-029 Load 9, after 2 decrements (o_count=7) load 2 -> o_count 2,1,0; exactly one o_done pulse; a later load of 0 mid-run -> IDLE with no pulse.
REQ-030 Load 15, reset asserted at o_count=7 -> o_count=0, IDLE, no o_done; then load 15 -> full count 15..0.
REQ-031 With DOWN_COUNTER_AUTORELOAD_EN: load 3 -> 3,2,1,0(done),3,2,1,0(done),...; load 0 -> IDLE, o_count stays 0.

Source files
------------

// File: rtl/down_counter.sv
// Loadable down counter with IDLE/RUN/DONE sequencing and a one-cycle terminal-count pulse.
// Optional auto-reload on terminal count is enabled by defining DOWN_COUNTER_AUTORELOAD_EN.
module down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_zero
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (i_load) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_d = i_load_value;
`endif
            // A zero load acts as an abort: back to IDLE, no done pulse.
            if (i_load_value != '0) begin
                state_d = StRun;
                count_d = i_load_value;
            end else begin
                state_d = StIdle;
                count_d = '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StRun: begin
                    if (i_enable) begin
                        // Terminal count; the <= guard also keeps a stray zero from wrapping.
                        if (count_q <= WIDTH'(1)) begin
                            state_d = StDone;
                            count_d = '0;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                StDone: begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                    if (reload_q != '0) begin
                        state_d = StRun;
                        count_d = reload_q;
                    end else begin
                        state_d = StIdle;
                        count_d = '0;
                    end
`else
                    state_d = StIdle;
                    count_d = '0;
`endif
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign o_count = count_q;
    assign o_busy  = (state_q == StRun);
    assign o_done  = (state_q == StDone);
    assign o_zero  = (count_q == '0);

endmodule
